// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save stream accumulator with serial (or single-cycle with CSA_ACC_FAST_RESOLVE_EN) resolve
module csa_stream_accumulator #(
  parameter int W  = 4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf,
  output logic [7:0]    out_count
);
  localparam logic [1:0] ACC = 2'd0, RESOLVE = 2'd1, DONE = 2'd2;
  logic [1:0]    state;
  logic [AW-1:0] s, c, res, x, maj;
  logic          ovf;
  logic [7:0]    count;
  assign in_ready  = state == ACC;
  assign out_valid = state == DONE;
  assign out_sum   = res;
  assign out_ovf   = ovf;
  assign out_count = count;
  assign x   = AW'(in_data);
  assign maj = (s & c) | (s & x) | (c & x);
`ifdef CSA_ACC_FAST_RESOLVE_EN
  logic [AW:0] full;
  assign full = {1'b0, s} + {1'b0, c};
`else
  localparam int CW = $clog2(AW);
  logic [CW-1:0] idx;
  logic          cy, rb, rc;
  // S and C shift right each cycle so bit 0 is always the bit being resolved
  assign rb = s[0] ^ c[0] ^ cy;
  assign rc = (s[0] & c[0]) | (s[0] & cy) | (c[0] & cy);
`endif
  always_ff @(posedge clk) begin
    if (rst || (state == DONE && out_ready)) begin
      state <= ACC;
      s     <= '0;
      c     <= '0;
      res   <= '0;
      ovf   <= 1'b0;
      count <= '0;
`ifndef CSA_ACC_FAST_RESOLVE_EN
      idx   <= '0;
      cy    <= 1'b0;
`endif
    end else if (state == ACC && in_valid) begin
      s     <= s ^ c ^ x;
      c     <= {maj[AW-2:0], 1'b0};
      ovf   <= ovf | maj[AW-1];
      count <= count + 8'(count != 8'hff);
      state <= in_last ? RESOLVE : ACC;
`ifndef CSA_ACC_FAST_RESOLVE_EN
      idx   <= '0;
      cy    <= 1'b0;
`endif
    end else if (state == RESOLVE) begin
`ifdef CSA_ACC_FAST_RESOLVE_EN
      res   <= full[AW-1:0];
      ovf   <= ovf | full[AW];
      state <= DONE;
`else
      s     <= {1'b0, s[AW-1:1]};
      c     <= {1'b0, c[AW-1:1]};
      res   <= {rb, res[AW-1:1]};
      cy    <= rc;
      idx   <= idx + CW'(1);
      if (idx == CW'(AW - 1)) begin
        ovf   <= ovf | rc;
        state <= DONE;
      end
`endif
    end
  end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: scoreboard bench for csa_stream_accumulator
module tb_csa_stream_accumulator;
  localparam int W  = 4;
  localparam int AW = 8;
`ifdef CSA_ACC_FAST_RESOLVE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = AW + 1;
`endif
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_ovf;
  logic [AW-1:0] out_sum;
  logic [7:0] out_count;
  int checks = 0, failures = 0;
  int q_sum[$], q_ovf[$], q_cnt[$];
  int acc_sum = 0, acc_cnt = 0;
  csa_stream_accumulator #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Scoreboard: pop and compare whenever a result handshake is about to occur
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q_sum.size() == 0) chk("sb_unexpected_result", 1, 0);
      else begin
        chk("out_sum", int'(out_sum), q_sum.pop_front());
        chk("out_ovf", int'(out_ovf), q_ovf.pop_front());
        chk("out_count", int'(out_count), q_cnt.pop_front());
      end
    end
  end
  // mode: 0 = do not wait for result, 1 = wait and step past handshake edge, 2 = wait and stay in DONE
  task automatic send_op(input int d, input bit last, input int gap, input bit keep, input int mode);
    int n;
    in_valid = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1; in_data = W'(d); in_last = last;
    @(negedge clk);
    chk("in_ready_acc", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; in_data = '0;
    acc_sum += d; acc_cnt++;
    if (last) begin
      if (keep) begin
        q_sum.push_back(acc_sum % (1 << AW));
        q_ovf.push_back(acc_sum >= (1 << AW) ? 1 : 0);
        q_cnt.push_back(acc_cnt > 255 ? 255 : acc_cnt);
      end
      acc_sum = 0; acc_cnt = 0;
      if (mode != 0) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 40);
        chk("latency", n, LAT);
        if (mode == 1) begin @(posedge clk); #1; end
      end
    end
  endtask
  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_out_count", int'(out_count), 0);
    @(posedge clk); #1;
    send_op(15, 0, 0, 1, 0); send_op(15, 0, 0, 1, 0); send_op(15, 1, 0, 1, 1);
    for (int i = 0; i < 18; i++) send_op(15, i == 17, 0, 1, 1);
    send_op(7, 1, 0, 1, 1);
    out_ready = 0;
    send_op(1, 0, 0, 1, 0); send_op(2, 0, 0, 1, 0); send_op(3, 1, 0, 1, 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_sum", int'(out_sum), 6);
      chk("hold_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_hs_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    send_op(4, 0, 0, 1, 0); send_op(4, 1, 0, 1, 1);
    send_op(9, 0, 0, 0, 0); send_op(9, 1, 0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    chk("rst_mid_count", int'(out_count), 0);
    seen = 0;
    repeat (15) begin @(negedge clk); if (out_valid) seen++; end
    chk("discarded_no_valid", seen, 0);
    @(posedge clk); #1;
    send_op(1, 0, 0, 1, 0); send_op(2, 1, 0, 1, 1);
    send_op(5, 0, 0, 1, 0); send_op(6, 0, 3, 1, 0); send_op(7, 1, 1, 1, 1);
    for (int i = 0; i < 260; i++) send_op(int'($urandom_range(0, 15)), i == 259, 0, 1, i == 259 ? 1 : 0);
    repeat (3) @(posedge clk);
    chk("sb_empty", q_sum.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
